// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority voting per bit and a
// valid/ack output handshake. Decisions are made on the synchronised line only.
module uart_rx_oversample #(
  parameter int CLK_HZ    = 48000000,
  parameter int BAUD_SLOW = 9600,
  parameter int BAUD_FAST = 38400,
  parameter int OS        = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RX_IN,
  input  logic       BAUD_SEL,
  input  logic       RX_ACK,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN,
  output logic       RX_BUSY
);

  localparam int DIV_SLOW = (CLK_HZ + BAUD_SLOW * OS / 2) / (BAUD_SLOW * OS);
  localparam int DIV_FAST = (CLK_HZ + BAUD_FAST * OS / 2) / (BAUD_FAST * OS);
  localparam int DIV_MAX  = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int TW       = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int SW       = $clog2(OS);

  // Sample-point constants are the value of s on the tick that advances s to the point.
  localparam logic [SW-1:0] S_V0   = SW'(OS / 2 - 2);
  localparam logic [SW-1:0] S_V1   = SW'(OS / 2 - 1);
  localparam logic [SW-1:0] S_DEC  = SW'(OS / 2);
  localparam logic [SW-1:0] S_LAST = SW'(OS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q, rx_prev_q;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            v0_q, v0_d, v1_q, v1_d;
  logic            baud_q, baud_d;
  logic            armed_q, armed_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_q, busy_d;

  logic [TW-1:0]   div_m1;
  logic            tick_wrap, decide, bit_end, maj;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    s_d         = s_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    v0_d        = v0_q;
    v1_d        = v1_q;
    baud_d      = baud_q;
    armed_d     = armed_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    div_m1    = baud_q ? TW'(DIV_FAST - 1) : TW'(DIV_SLOW - 1);
    tick_wrap = (tick_q == div_m1);
    decide    = tick_wrap && (s_q == S_DEC);
    bit_end   = tick_wrap && (s_q == S_LAST);
    maj       = (v0_q & v1_q) | (v0_q & rx_s_q) | (v1_q & rx_s_q);

    if (RX_ACK) rx_valid_d = 1'b0;

    if (state_q != ST_IDLE) begin
      tick_d = tick_wrap ? '0 : tick_q + TW'(1);
      if (tick_wrap) s_d = s_q + SW'(1);
      if (tick_wrap && s_q == S_V0) v0_d = rx_s_q;
      if (tick_wrap && s_q == S_V1) v1_d = rx_s_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_s_q) armed_d = 1'b1;
        if (armed_q && rx_prev_q && !rx_s_q) begin
          state_d = ST_START;
          tick_d  = '0;
          s_d     = '0;
          baud_d  = BAUD_SEL;
        end
      end
      ST_START: begin
        if (decide && maj) begin
          state_d = ST_IDLE;
        end else if (bit_end) begin
          state_d = ST_DATA;
          idx_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (decide) shreg_d = {maj, shreg_q[7:1]};
        if (bit_end) begin
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      ST_STOP: begin
        // Leave mid stop bit so a back-to-back start edge is never missed.
        if (decide) begin
          state_d = ST_IDLE;
          if (maj) begin
            rx_data_d  = shreg_q;
            rx_valid_d = 1'b1;
            overrun_d  = rx_valid_q && !RX_ACK;
          end else begin
            frame_err_d = 1'b1;
            armed_d     = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      s_q         <= '0;
      idx_q       <= 3'd0;
      shreg_q     <= 8'h00;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      baud_q      <= 1'b0;
      armed_q     <= 1'b1;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= RX_IN;
      rx_s_q      <= sync1_q;
      rx_prev_q   <= rx_s_q;
      state_q     <= state_d;
      tick_q      <= tick_d;
      s_q         <= s_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      baud_q      <= baud_d;
      armed_q     <= armed_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
  assign RX_BUSY   = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample; a scaled-down clock keeps whole frames short.
// Expected bytes are queued as frames are sent and checked as the receiver delivers them.
module tb_uart_rx_oversample;
  localparam int CLK_HZ    = 12000000;
  localparam int BAUD_SLOW = 9600;
  localparam int BAUD_FAST = 38400;
  localparam int OS        = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       baud_sel = 1'b0;
  logic       rx_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overrun, rx_busy;

  uart_rx_oversample #(
    .CLK_HZ(CLK_HZ), .BAUD_SLOW(BAUD_SLOW), .BAUD_FAST(BAUD_FAST), .OS(OS)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .RX_IN(rx_in), .BAUD_SEL(baud_sel), .RX_ACK(rx_ack),
    .RX_DATA(rx_data), .RX_VALID(rx_valid), .FRAME_ERR(frame_err),
    .OVERRUN(overrun), .RX_BUSY(rx_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         tests_run = 0, tests_failed = 0;
  int         div_slow, div_fast;
  logic [7:0] sb[$];
  logic [7:0] exp_b;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       auto_ack = 1'b1;
  int         land_cnt = 0, land_cyc = 0, start_cyc = 0;
  int         ovr_cnt = 0, ferr_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    tests_run++;
    assert (obs >= lo && obs <= hi) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One clock: observe outputs at the falling edge, score delivered bytes, drive ack.
  task automatic step();
    @(negedge clk);
    if (rx_valid && (!valid_prev || rx_data !== data_prev || overrun)) begin
      land_cnt++;
      land_cyc = cyc;
      check("sb_has_entry", int'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        exp_b = sb.pop_front();
        check("rx_data", int'(rx_data), int'(exp_b));
      end
    end
    if (overrun)   ovr_cnt++;
    if (frame_err) ferr_cnt++;
    valid_prev = rx_valid;
    data_prev  = rx_data;
    rx_ack     = auto_ack && rx_valid && !rx_ack;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      rx_in = 1'b1;
    end
  endtask

  // Drives the first nbits of a frame; glitch_bit inverts only the centre vote of that bit.
  // BAUD_SEL is flipped mid-frame to show it only matters when a frame starts.
  task automatic send_byte(input logic [7:0] d, input logic stop, input logic sel,
                           input int nbits, input int glitch_bit);
    int         div, bp;
    logic [9:0] frame;
    logic       v;
    div   = sel ? div_fast : div_slow;
    bp    = OS * div;
    frame = {stop, d, 1'b0};
    baud_sel = sel;
    for (int b = 0; b < nbits; b++) begin
      v = frame[4'(b)];
      for (int c = 0; c < bp; c++) begin
        step();
        if (b == 0 && c == 0) start_cyc = cyc;
        if (b == 1 && c == 0) baud_sel = ~sel;
        if (b == glitch_bit && c >= (OS / 2) * div - div / 2 && c < (OS / 2) * div + div / 2)
          rx_in = ~v;
        else
          rx_in = v;
      end
    end
  endtask

  initial begin
    int lat_slow, t, bound;
    logic busy_seen;
    div_slow = $rtoi(real'(CLK_HZ) / real'(BAUD_SLOW * OS) + 0.5);
    div_fast = $rtoi(real'(CLK_HZ) / real'(BAUD_FAST * OS) + 0.5);
    lat_slow = (9 * OS + OS / 2 + 1) * div_slow;

    // Reset with the line toggling
    rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      rx_in = i[0];
    end
    check("rst_rx_data", int'(rx_data), 0);
    check("rst_rx_valid", int'(rx_valid), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_rx_busy", int'(rx_busy), 0);
    rx_in = 1'b1;
    idle(2);
    rst_n = 1'b1;
    idle(50);
    check("post_rst_busy", int'(rx_busy), 0);
    check("post_rst_valid", int'(rx_valid), 0);

    // 0x55 at the slow rate, with latency measurement
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b1, 1'b0, 10, -1);
    idle(100);
    check("t2_sb_drained", sb.size(), 0);
    check("t2_land_cnt", land_cnt, 1);
    check_range("t2_latency", land_cyc - start_cyc, lat_slow + 2, lat_slow + 3);
    check("t2_ferr", ferr_cnt, 0);
    check("t2_valid_acked", int'(rx_valid), 0);

    // "va" back-to-back at the fast rate; centre-sample glitch on the first data bit
    sb.push_back(8'h76);
    sb.push_back(8'h61);
    send_byte(8'h76, 1'b1, 1'b1, 10, 1);
    send_byte(8'h61, 1'b1, 1'b1, 10, -1);
    idle(100);
    check("t3_sb_drained", sb.size(), 0);
    check("t3_land_cnt", land_cnt, 3);
    check("t3_overrun", ovr_cnt, 0);
    check("t3_ferr", ferr_cnt, 0);

    // 48-clock low pulse is a false start
    baud_sel = 1'b0;
    step();
    rx_in = 1'b0;
    t = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 47; i++) begin
      step();
      t++;
      if (rx_busy) busy_seen = 1'b1;
    end
    step();
    t++;
    rx_in = 1'b1;
    bound = (OS / 2 + 1) * div_slow + 8;
    while (rx_busy && t < bound) begin
      step();
      t++;
    end
    check("t4_busy_rose", int'(busy_seen), 1);
    check_range("t4_idle_after", t, (OS / 2 + 1) * div_slow + 2, (OS / 2 + 1) * div_slow + 4);
    idle(50);
    check("t4_no_byte", land_cnt, 3);
    check("t4_valid", int'(rx_valid), 0);

    // Bad stop bit, then a good byte
    send_byte(8'hA5, 1'b0, 1'b0, 10, -1);
    check("t5_valid_after_ferr", int'(rx_valid), 0);
    check("t5_ferr_one_cycle", ferr_cnt, 1);
    check("t5_no_byte", land_cnt, 3);
    idle(OS * div_slow);
    sb.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 1'b0, 10, -1);
    idle(100);
    check("t5_sb_drained", sb.size(), 0);
    check("t5_land_cnt", land_cnt, 4);
    check("t5_ferr_total", ferr_cnt, 1);

    // Overrun without ack, then reset mid-frame
    auto_ack = 1'b0;
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send_byte(8'h11, 1'b1, 1'b1, 10, -1);
    send_byte(8'h22, 1'b1, 1'b1, 10, -1);
    idle(20);
    check("t6_overrun_one_cycle", ovr_cnt, 1);
    check("t6_valid_held", int'(rx_valid), 1);
    check("t6_data_overwritten", int'(rx_data), 8'h22);
    check("t6_land_cnt", land_cnt, 6);
    send_byte(8'h33, 1'b1, 1'b1, 5, -1);
    rst_n = 1'b0;
    rx_in = 1'b1;
    idle(4);
    check("t6_rst_data", int'(rx_data), 0);
    check("t6_rst_valid", int'(rx_valid), 0);
    check("t6_rst_busy", int'(rx_busy), 0);
    rst_n = 1'b1;
    auto_ack = 1'b1;
    idle(400);
    sb.push_back(8'h4B);
    send_byte(8'h4B, 1'b1, 1'b1, 10, -1);
    idle(100);
    check("t6_sb_drained", sb.size(), 0);
    check("t6_land_cnt", land_cnt, 7);
    check("t6_overrun_total", ovr_cnt, 1);
    check("t6_valid_acked", int'(rx_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
